// File: rtl/cpu_pkg.sv
// Shared types for the accumulator core: opcodes, FSM states, ALU ops, skip codes.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

  localparam int OPC_WIDTH = 4;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h6,
    OP_HALT  = 4'h7,
    OP_SKIP  = 4'h8,
    OP_JUMP  = 4'h9,
    OP_CLEAR = 4'hA,
    OP_OR    = 4'hC,
    OP_NOT   = 4'hD,
    OP_JUMPI = 4'hE
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOT
  } alu_op_e;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/accum_cpu_core_if.sv
// Single-port memory bus between the core (master) and a memory (slave).
// req/ready handshake: a request completes on the rising edge where ready is high.
interface accum_cpu_core_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/accum_cpu_core_alu.sv
// Combinational accumulator ALU, y = op(a, b); zero latency, no flow control.
module accum_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_e               op,
  output logic [DATA_WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOT: y = ~b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator CPU: fetch/decode/exec/wb FSM; 2-4 cycles per instruction at zero wait.
// A request with ready low holds the bus and stalls the FSM one cycle per wait.
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  accum_cpu_core_if.master      mem,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  halted,
  output logic                  illegal
);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d, ir_q, ir_d, mbr_q, mbr_d;
  logic                  ill_q, ill_d;

  logic                  req, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  opcode_e               opc;
  logic [ADDR_WIDTH-1:0] operand, pc_inc;
  logic [1:0]            skip_code;
  logic                  ac_neg, ac_zero, skip_take;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] alu_y;

  assign opc       = opcode_e'(ir_q[DATA_WIDTH-1 -: OPC_WIDTH]);
  assign operand   = ir_q[ADDR_WIDTH-1:0];
  // Skip code sits at IR[11:10] independent of ADDR_WIDTH.
  assign skip_code = ir_q[11:10];
  assign pc_inc    = pc_q + PC_ONE;
  assign ac_neg    = ac_q[DATA_WIDTH-1];
  assign ac_zero   = (ac_q == '0);

  always_comb begin
    skip_take = 1'b0;
    case (skip_code)
      SKIP_NEG:  skip_take = ac_neg;
      SKIP_ZERO: skip_take = ac_zero;
      SKIP_POS:  skip_take = !ac_neg && !ac_zero;
      default:   skip_take = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (opc)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_NOT:  alu_op = ALU_NOT;
      default: alu_op = ALU_ADD;
    endcase
  end

  accum_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a  (ac_q),
    .b  (mbr_q),
    .op (alu_op),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    mbr_d   = mbr_q;
    ill_d   = ill_q;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    case (state_q)
      S_FETCH: begin
        req  = 1'b1;
        addr = pc_q;
        if (mem.ready) begin
          ir_d    = mem.rdata;
          pc_d    = pc_inc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opc)
          OP_CLEAR: ac_d = '0;
          OP_JUMP:  pc_d = operand;
          OP_SKIP:  if (skip_take) pc_d = pc_inc;
          OP_HALT:  state_d = S_HALT;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_NOT, OP_JUMPI: state_d = S_EXEC;
          default: begin
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        req   = 1'b1;
        addr  = operand;
        we    = (opc == OP_STORE);
        wdata = (opc == OP_STORE) ? ac_q : '0;
        if (mem.ready) begin
          state_d = S_FETCH;
          case (opc)
            OP_STORE: ;
            OP_LOAD:  ac_d = mem.rdata;
            OP_JUMPI: pc_d = mem.rdata[ADDR_WIDTH-1:0];
            default: begin
              mbr_d   = mem.rdata;
              state_d = S_WB;
            end
          endcase
        end
      end
      S_WB: begin
        ac_d    = alu_y;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ac_q    <= '0;
      ir_q    <= '0;
      mbr_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      mbr_q   <= mbr_d;
      ill_q   <= ill_d;
    end
  end

  // Bus is forced idle while reset is held so a pending request drops at once.
  assign mem.req   = req & rst_n;
  assign mem.we    = we & rst_n;
  assign mem.addr  = rst_n ? addr : '0;
  assign mem.wdata = rst_n ? wdata : '0;

  assign pc_out  = pc_q;
  assign ac_out  = ac_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = ill_q;
endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed and randomized checks of accum_cpu_core against an instruction-level model.
module tb_accum_cpu_core;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic rst_w_n = 1'b0;

  accum_cpu_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  accum_cpu_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_w ();

  logic [AW-1:0] pc_out, pc_w;
  logic [DW-1:0] ac_out, ac_w;
  logic          halted, illegal, halted_w, illegal_w;

  accum_cpu_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(12'h100)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus),
    .pc_out(pc_out), .ac_out(ac_out), .halted(halted), .illegal(illegal)
  );

  accum_cpu_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(12'hFFF)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .mem(bus_w),
    .pc_out(pc_w), .ac_out(ac_w), .halted(halted_w), .illegal(illegal_w)
  );

  // Memory for the main core, with a bench load port used while the core is in reset.
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_dat = '0;
  logic          rdy = 1'b0;

  assign bus.ready = rdy;
  assign bus.rdata = mem[bus.addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (bus.req && bus.we && bus.ready) mem[bus.addr] <= bus.wdata;
  end

  // Wrap core sees CLEAR at the top address and HALT at 0.
  assign bus_w.ready = 1'b1;
  assign bus_w.rdata = (bus_w.addr == 12'hFFF) ? 16'hA000 :
                       (bus_w.addr == 12'h000) ? 16'h7000 : 16'h0000;

  // Ready generator with 0..max_wait wait cycles per transaction, plus hold-rule monitor.
  int            max_wait = 0;
  int            wait_left = 0;
  bit            pending_new = 1'b1;
  bit            hold_prev = 1'b0;
  int            hold_seen = 0;
  int            hold_viol = 0;
  logic [AW-1:0] p_addr, p_pc;
  logic          p_we;
  logic [DW-1:0] p_wdata;

  always @(negedge clk) begin
    if (hold_prev && rst_n) begin
      hold_seen++;
      if (bus.req !== 1'b1 || bus.addr !== p_addr || bus.we !== p_we ||
          bus.wdata !== p_wdata || pc_out !== p_pc)
        hold_viol++;
    end
    if (bus.req === 1'b1) begin
      if (pending_new) begin
        wait_left   = $urandom_range(max_wait, 0);
        pending_new = 1'b0;
      end
      if (wait_left == 0) begin
        rdy         = 1'b1;
        pending_new = 1'b1;
      end else begin
        rdy = 1'b0;
        wait_left--;
      end
    end else begin
      rdy = 1'b0;
    end
    hold_prev = (bus.req === 1'b1) && !rdy;
    p_addr    = bus.addr;
    p_we      = bus.we;
    p_wdata   = bus.wdata;
    p_pc      = pc_out;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_addr    = a;
    ld_dat     = d;
    ld_en      = 1'b1;
    ref_mem[a] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Reset the core, release it and count cycles until halted (bounded).
  task automatic run(input int mw, output int cyc);
    bit to;
    max_wait = mw;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    to  = 1'b0;
    while (halted !== 1'b1) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc >= 3000) begin
        to = 1'b1;
        break;
      end
    end
    chk("run_timeout", {31'd0, to}, 32'd0);
  endtask

  // Instruction-level reference: executes ref_mem from start, counts zero-wait cycles.
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ac;
  bit            m_halt, m_ill;
  int            m_cyc;

  task automatic model_run(input logic [AW-1:0] start);
    logic [DW-1:0] ir;
    logic [AW-1:0] opr;
    bit            skip;
    m_pc = start; m_ac = '0; m_halt = 0; m_ill = 0; m_cyc = 0;
    for (int steps = 0; steps < 1000 && !m_halt; steps++) begin
      ir   = ref_mem[m_pc];
      m_pc = m_pc + 12'd1;
      opr  = ir[AW-1:0];
      case (ir[15:12])
        4'h1: begin m_ac = ref_mem[opr]; m_cyc += 3; end
        4'h2: begin ref_mem[opr] = m_ac; m_cyc += 3; end
        4'h3: begin m_ac = m_ac + ref_mem[opr]; m_cyc += 4; end
        4'h4: begin m_ac = m_ac - ref_mem[opr]; m_cyc += 4; end
        4'h6: begin m_ac = m_ac & ref_mem[opr]; m_cyc += 4; end
        4'hC: begin m_ac = m_ac | ref_mem[opr]; m_cyc += 4; end
        4'hD: begin m_ac = ~ref_mem[opr]; m_cyc += 4; end
        4'h7: begin m_halt = 1; m_cyc += 2; end
        4'h8: begin
          skip = (ir[11:10] == 2'd0 && $signed(m_ac) < 0) ||
                 (ir[11:10] == 2'd1 && m_ac == 0) ||
                 (ir[11:10] == 2'd2 && $signed(m_ac) > 0);
          if (skip) m_pc = m_pc + 12'd1;
          m_cyc += 2;
        end
        4'h9: begin m_pc = opr; m_cyc += 2; end
        4'hA: begin m_ac = '0; m_cyc += 2; end
        4'hE: begin m_pc = ref_mem[opr][AW-1:0]; m_cyc += 3; end
        default: begin m_ill = 1; m_halt = 1; m_cyc += 2; end
      endcase
    end
  endtask

  initial begin
    int            cyc;
    int            s0;
    logic [DW-1:0] acv;
    logic [3:0]    ops [9];
    logic [3:0]    op;
    logic [DW-1:0] ins;
    bit            exp_skip;
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hD};

    // Basic program, checked in reset then at zero wait.
    poke(12'h100, 16'h110B); poke(12'h101, 16'h310C);
    poke(12'h102, 16'h210D); poke(12'h103, 16'h7000);
    poke(12'h10B, 16'd5);    poke(12'h10C, 16'd7); poke(12'h10D, 16'd0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_addr", {20'd0, bus.addr}, 32'd0);
    chk("rst_wdata", {16'd0, bus.wdata}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_pc", {20'd0, pc_out}, 32'h100);
    chk("rst_ac", {16'd0, ac_out}, 32'd0);
    run(0, cyc);
    chk("p1_ac", {16'd0, ac_out}, 32'd12);
    chk("p1_mem", {16'd0, mem[12'h10D]}, 32'd12);
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_illegal", {31'd0, illegal}, 32'd0);
    chk("p1_pc", {20'd0, pc_out}, 32'h104);
    chk("p1_cycles", cyc, 32'd12);

    // Same program with random wait states.
    s0 = hold_seen;
    for (int r = 0; r < 3; r++) begin
      rst_n = 1'b0;
      poke(12'h10D, 16'd0);
      run(3, cyc);
      chk("p2_ac", {16'd0, ac_out}, 32'd12);
      chk("p2_mem", {16'd0, mem[12'h10D]}, 32'd12);
      chk("p2_pc", {20'd0, pc_out}, 32'h104);
      chk("p2_halted", {31'd0, halted}, 32'd1);
    end
    chk("p2_stalls_seen", {31'd0, hold_seen > s0}, 32'd1);

    // SKIPCOND over AC = -1, 0, 3 and all four codes.
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 4; c++) begin
        rst_n = 1'b0;
        if (v == 1) poke(12'h100, 16'hA000);
        else begin
          poke(12'h100, 16'h110B);
          poke(12'h10B, (v == 0) ? 16'hFFFF : 16'h0003);
        end
        ins = 16'h8000 | (16'(c) << 10);
        poke(12'h101, ins);
        poke(12'h102, 16'h7000); poke(12'h103, 16'h7000);
        exp_skip = (c == 0 && v == 0) || (c == 1 && v == 1) || (c == 2 && v == 2);
        run(0, cyc);
        chk($sformatf("skip_v%0d_c%0d", v, c), {20'd0, pc_out}, exp_skip ? 32'h104 : 32'h103);
      end
    end

    // Indirect jump.
    rst_n = 1'b0;
    poke(12'h100, 16'hE120); poke(12'h120, 16'h0140); poke(12'h140, 16'h7000);
    run(0, cyc);
    chk("jumpi_pc", {20'd0, pc_out}, 32'h141);
    chk("jumpi_halted", {31'd0, halted}, 32'd1);
    chk("jumpi_cycles", cyc, 32'd5);

    // Illegal opcode, then silence on the bus.
    rst_n = 1'b0;
    poke(12'h100, 16'hF000);
    run(0, cyc);
    chk("ill_illegal", {31'd0, illegal}, 32'd1);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_pc", {20'd0, pc_out}, 32'h101);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk("ill_no_req", {31'd0, bus.req}, 32'd0);
    end

    // Reset asserted while an EXEC read is pending.
    rst_n = 1'b0;
    poke(12'h100, 16'h110B); poke(12'h10B, 16'd5);
    max_wait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_exec_req", {31'd0, bus.req}, 32'd1);
    chk("mid_exec_addr", {20'd0, bus.addr}, 32'h10B);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.req}, 32'd0);
    chk("mid_rst_addr", {20'd0, bus.addr}, 32'd0);
    chk("mid_rst_pc", {20'd0, pc_out}, 32'h100);
    chk("mid_rst_ac", {16'd0, ac_out}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    chk("mid_rst_illegal", {31'd0, illegal}, 32'd0);

    // PC wrap on the second core.
    chk("wrap_rst_req", {31'd0, bus_w.req}, 32'd0);
    @(posedge clk);
    #1 rst_w_n = 1'b1;
    #1;
    chk("wrap_fetch_top", {20'd0, bus_w.addr}, 32'hFFF);
    chk("wrap_fetch_req", {31'd0, bus_w.req}, 32'd1);
    @(posedge clk);
    #1 chk("wrap_pc0", {20'd0, pc_w}, 32'd0);
    @(posedge clk);
    #1 chk("wrap_fetch_zero", {20'd0, bus_w.addr}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("wrap_halted", {31'd0, halted_w}, 32'd1);
    chk("wrap_pc_end", {20'd0, pc_w}, 32'd1);
    chk("wrap_illegal", {31'd0, illegal_w}, 32'd0);

    // Random programs against the instruction-level model.
    for (int t = 0; t < 8; t++) begin
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) poke(12'h200 + 12'(i), 16'($urandom));
      for (int k = 0; k < 8; k++) begin
        op = ops[$urandom_range(8, 0)];
        if (op == 4'h8) ins = 16'h8000 | (16'($urandom_range(3, 0)) << 10);
        else if (op == 4'hA) ins = 16'hA000;
        else ins = {op, 12'h200 + 12'($urandom_range(15, 0))};
        poke(12'h100 + 12'(k), ins);
      end
      poke(12'h108, 16'h7000); poke(12'h109, 16'h7000);
      model_run(12'h100);
      run((t % 2) * 3, cyc);
      chk($sformatf("rnd%0d_ac", t), {16'd0, ac_out}, {16'd0, m_ac});
      chk($sformatf("rnd%0d_pc", t), {20'd0, pc_out}, {20'd0, m_pc});
      chk($sformatf("rnd%0d_halted", t), {31'd0, halted}, {31'd0, m_halt});
      chk($sformatf("rnd%0d_illegal", t), {31'd0, illegal}, {31'd0, m_ill});
      if (t % 2 == 0) chk($sformatf("rnd%0d_cycles", t), cyc, m_cyc);
      for (int i = 0; i < 16; i++) begin
        acv = ref_mem[12'h200 + 12'(i)];
        chk($sformatf("rnd%0d_mem%0d", t, i), {16'd0, mem[12'h200 + 12'(i)]}, {16'd0, acv});
      end
    end

    chk("hold_rule_violations", hold_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accum_cpu_core.md
Name: accum_cpu_core

Overview:
Synthesisable, parametrised accumulator CPU core. It is the successor to the behavioural fetch/execute loop used in our CPU testbench. It runs a fetch/decode/execute FSM against an external single-port memory over a req/ready handshake, so wait-state memories and caches can sit behind it. Word and address widths are generic. The core adds proper halt and illegal-opcode handling, signed skip conditions and indirect jump.

Parameters:
DATA_WIDTH, 16, width of the accumulator, memory word and instruction; must be >= ADDR_WIDTH+4.
ADDR_WIDTH, 12, memory address width; operand = IR[ADDR_WIDTH-1:0].
RESET_PC, 'h100, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_req  out  1  memory transaction request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_WIDTH  transaction address.
mem_wdata  out  DATA_WIDTH  store data.
mem_rdata  in  DATA_WIDTH  read data; valid in the cycle mem_ready is high.
mem_ready  in  1  completes the pending request at this rising edge; may be high in the same cycle mem_req rises.
pc_out  out  ADDR_WIDTH  current PC.
ac_out  out  DATA_WIDTH  current AC.
halted  out  1  core stopped (HALT or illegal opcode).
illegal  out  1  stopped because of an unknown opcode.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, AC=0, IR=0, MBR=0, state=FETCH. mem_req, mem_we, mem_addr, mem_wdata, halted and illegal all 0. Release is synchronous to clk.
- Opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4]. Encodings: 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 6 AND, 7 HALT, 8 SKIPCOND, 9 JUMP, A CLEAR, C OR, D NOT, E JUMPI. Encodings 0, 5, B and F are illegal.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On the ready edge, IR<=rdata and PC<=PC+1 (mod 2^ADDR_WIDTH), then go to DECODE.
- DECODE, single-cycle opcodes (each returns to FETCH):
  - CLEAR: AC<=0.
  - JUMP: PC<=operand.
  - SKIPCOND: IR[11:10]=00 and AC<0 (signed), or 01 and AC==0, or 10 and AC>0 (signed), gives PC<=PC+1. Code 11 never skips.
  - HALT: go to HALT.
  - Illegal opcode: set illegal=1 and go to HALT.
- DECODE, memory opcodes: all others go to EXEC.
- EXEC: mem_req=1, mem_addr=operand. mem_we=1 and mem_wdata=AC for STORE; read otherwise.
  - On the ready edge: STORE goes to FETCH; LOAD sets AC<=rdata and goes to FETCH; JUMPI sets PC<=rdata[ADDR_WIDTH-1:0] and goes to FETCH.
  - ADD, SUB, AND, OR, NOT: MBR<=rdata, go to WB.
- WB: AC <= ALU(AC, MBR). ADD and SUB are modulo 2^DATA_WIDTH. NOT yields ~MBR. Then go to FETCH.
- Outside FETCH and EXEC: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request hold rule: while mem_req is high and mem_ready is low, mem_addr, mem_we and mem_wdata stay stable and the FSM does not advance.
- Zero-wait latency (ready tied high):
  - 2 cycles: CLEAR, JUMP, SKIPCOND.
  - 3 cycles: LOAD, STORE, JUMPI.
  - 4 cycles: ADD, SUB, AND, OR, NOT.
  - Each additional ready-low cycle adds exactly one cycle.
- HALT state: halted=1, no requests are issued, all registers are frozen. Only reset exits it.
- Reset mid-transaction: the request is abandoned immediately. The memory must tolerate mem_req dropping without ready.
- PC wrap: at PC = 2^ADDR_WIDTH-1, fetch followed by increment gives 0. The PC+1 from SKIPCOND wraps the same way.

Decomposition:
- Shared package cpu_pkg:
  - opcode_e enum.
  - state_e enum.
  - alu_op_e enum: ADD, SUB, AND, OR, NOT.
  - Skip-condition code constants.
  - OPC_WIDTH=4 constant.
- One sub-module, accum_alu: combinational, parametrised by DATA_WIDTH, inputs a, b and alu_op_e, output y.
- The FSM, the registers and the handshake all stay in accum_cpu_core.

Test Plan:
1. Zero-wait program at 'h100: LOAD 'h10B (mem=5), ADD 'h10C (mem=7), STORE 'h10D, HALT -> mem['h10D]=12, AC=12, halted=1, illegal=0, PC='h104.
2. Random 0–3-cycle mem_ready delays on the same program -> identical final state; mem_addr, mem_we and mem_wdata stable on every ready-low cycle.
3. SKIPCOND with AC=-1 (all ones), 0 and 3, using codes 00, 01, 10, 11 -> PC advances by 2 exactly for (00,-1), (01,0), (10,3); otherwise by 1.
4. JUMPI 'h120 with mem['h120]='h140, where 'h140 holds HALT -> PC='h141, halted=1.
5. Opcode F at 'h100 -> illegal=1, halted=1, no further mem_req. Assert rst_n=0 mid-EXEC of a later run -> all outputs return to reset values in the same cycle, PC='h100.
6. PC wrap: RESET_PC=2^ADDR_WIDTH-1 holding CLEAR, 0 holding HALT -> fetch at the top address, then at 0, halted=1.
